// File: rtl/instruction_fetch.sv
// instruction_fetch: program counter sequencer that fetches one instruction at a time and issues it to the decoder
//   clk, reset          : clock and synchronous active-high reset
//   imem_addr, imem_req : fetch address (= PC) and request, held until imem_ack
//   imem_ack, imem_rdata: memory response, data valid with ack
//   COMMAND, cmd_valid  : instruction register and its valid flag
//   cmd_ready           : execute side accepts COMMAND
//   PC_load, branch_target : taken-branch redirect, sampled only on accept
//   pc_out              : address of the instruction in COMMAND
//   halted              : HLT accepted, fetching stopped until reset
//   instr_count         : accepted instruction count, wraps
module instruction_fetch #(
   parameter int ADDR_W = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_req,
   input  logic              imem_ack,
   input  logic [15:0]       imem_rdata,
   output logic [15:0]       COMMAND,
   output logic              cmd_valid,
   input  logic              cmd_ready,
   input  logic              PC_load,
   input  logic [ADDR_W-1:0] branch_target,
   output logic [ADDR_W-1:0] pc_out,
   output logic              halted,
   output logic [15:0]       instr_count
);
   typedef enum logic [1:0] {BOOT, FETCH, ISSUE, HALT} state_t;
   state_t state, state_nx;
   logic [ADDR_W-1:0] pc, pc_nx;
   logic [15:0] ir, ir_nx, cnt, cnt_nx;
   logic is_hlt;
   assign is_hlt = ir[15:14] == 2'b11 && ir[7:4] == 4'b1111;
   always_ff @(posedge clk)
      if (reset) begin
         state <= BOOT;
         pc <= RESET_PC;
         ir <= '0;
         cnt <= '0;
      end else begin
         state <= state_nx;
         pc <= pc_nx;
         ir <= ir_nx;
         cnt <= cnt_nx;
      end
   always_comb begin
      state_nx = state;
      pc_nx = pc;
      ir_nx = ir;
      cnt_nx = cnt;
      case (state)
         BOOT: state_nx = FETCH;
         FETCH: if (imem_ack) begin
            ir_nx = imem_rdata;
            state_nx = ISSUE;
         end
         ISSUE: if (cmd_ready) begin
            cnt_nx = cnt + 16'd1;
            state_nx = is_hlt ? HALT : FETCH;
            // HLT keeps its own address so pc_out still names it while halted
            pc_nx = is_hlt ? pc : PC_load ? branch_target : pc + ADDR_W'(1);
         end
         default: ;
      endcase
   end
   assign imem_addr = pc;
   assign imem_req = state == FETCH;
   assign COMMAND = ir;
   assign cmd_valid = state == ISSUE;
   assign pc_out = pc;
   assign halted = state == HALT;
   assign instr_count = cnt;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench for instruction_fetch against a program-level reference model
module tb_instruction_fetch;
   logic clk = 0, reset = 1, imem_ack = 0, cmd_ready = 0, PC_load = 0;
   logic [15:0] branch_target = 0;
   logic [15:0] imem_addr, imem_rdata, COMMAND, pc_out, instr_count;
   logic imem_req, cmd_valid, halted;
   logic [15:0] u1_addr, u1_cmd, u1_pc, u1_cnt;
   logic u1_req, u1_valid, u1_halted;
   logic [15:0] mem [0:65535];
   int vecs = 0, errs = 0, accepts = 0;
   always #5 clk = ~clk;
   assign imem_rdata = mem[imem_addr];

   instruction_fetch #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
      .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_req(imem_req),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .COMMAND(COMMAND),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .PC_load(PC_load),
      .branch_target(branch_target), .pc_out(pc_out), .halted(halted),
      .instr_count(instr_count));

   instruction_fetch #(.ADDR_W(16), .RESET_PC(16'hFFFF)) u1 (
      .clk(clk), .reset(reset), .imem_addr(u1_addr), .imem_req(u1_req),
      .imem_ack(1'b1), .imem_rdata(16'h0001), .COMMAND(u1_cmd),
      .cmd_valid(u1_valid), .cmd_ready(1'b1), .PC_load(1'b0),
      .branch_target(16'h0000), .pc_out(u1_pc), .halted(u1_halted),
      .instr_count(u1_cnt));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic hlt_word(input logic [15:0] w);
      return w[15:14] == 2'b11 && w[7:4] == 4'b1111;
   endfunction

   // Reference model: the expected program stream, one entry per instruction to be issued
   typedef struct packed {logic [15:0] cmd; logic [15:0] pc;} exp_t;
   exp_t q[$];
   exp_t e;
   logic [15:0] exp_cnt, hpc, hcmd, npc;
   logic exp_halt, nf, rst_d;
   always @(posedge clk) rst_d <= reset;

   always @(negedge clk) begin
      if (rst_d) begin
         chk("rst_req", imem_req, 0);
         chk("rst_valid", cmd_valid, 0);
         chk("rst_halted", halted, 0);
         chk("rst_cmd", COMMAND, 0);
         chk("rst_cnt", instr_count, 0);
         chk("rst_pc", pc_out, 0);
         chk("rst_addr", imem_addr, 0);
         q.delete();
         q.push_back({mem[0], 16'h0000});
         exp_cnt = 0;
         exp_halt = 0;
         nf = 0;
      end else begin
         chk("count", instr_count, exp_cnt);
         chk("halted", halted, exp_halt);
         if (nf) chk("next_req", imem_req, 1);
         nf = 0;
         if (exp_halt) begin
            chk("halt_req", imem_req, 0);
            chk("halt_valid", cmd_valid, 0);
            chk("halt_pc", pc_out, hpc);
            chk("halt_cmd", COMMAND, hcmd);
         end else if (q.size() == 0) begin
            chk("model_empty", 1, 0);
         end else begin
            chk("req_and_valid", imem_req && cmd_valid, 0);
            if (imem_req) chk("addr", imem_addr, q[0].pc);
            if (cmd_valid) begin
               chk("cmd", COMMAND, q[0].cmd);
               chk("pc_out", pc_out, q[0].pc);
               if (cmd_ready) begin
                  e = q.pop_front();
                  exp_cnt = exp_cnt + 16'd1;
                  accepts++;
                  if (hlt_word(e.cmd)) begin
                     exp_halt = 1;
                     hpc = e.pc;
                     hcmd = e.cmd;
                  end else begin
                     npc = PC_load ? branch_target : e.pc + 16'd1;
                     q.push_back({mem[npc], npc});
                     nf = 1;
                  end
               end
            end
         end
      end
   end

   task automatic wait_valid(input string nm);
      int n = 0;
      @(negedge clk);
      while (!cmd_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk(nm, cmd_valid, 1);
   endtask

   task automatic accept_with(input logic pl, input logic [15:0] bt);
      @(posedge clk); #1 cmd_ready = 1; PC_load = pl; branch_target = bt;
      @(posedge clk); #1 cmd_ready = 0; PC_load = 0;
   endtask

   task automatic rst_pulse();
      @(posedge clk); #1 reset = 1;
      @(posedge clk); #1 reset = 0;
   endtask

   initial begin
      int n, a0;
      logic [15:0] w;
      for (int a = 0; a < 65536; a++) begin
         w = 16'($urandom) | 16'h0001;
         if (hlt_word(w)) w[4] = 1'b0;
         mem[a] = w;
      end
      mem[0] = 16'h1234;
      mem[5] = 16'hC0F0;
      imem_ack = 1;
      cmd_ready = 1;
      repeat (3) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      chk("c1_req", imem_req, 0);
      chk("c1_u1_req", u1_req, 0);
      @(negedge clk);
      chk("c2_req", imem_req, 1);
      chk("c2_addr", imem_addr, 16'h0000);
      chk("c2_u1_addr", u1_addr, 16'hFFFF);
      @(negedge clk);
      chk("c3_valid", cmd_valid, 1);
      chk("c3_cmd", COMMAND, 16'h1234);
      chk("c3_pc", pc_out, 16'h0000);
      chk("c3_u1_valid", u1_valid, 1);
      chk("c3_u1_pc", u1_pc, 16'hFFFF);
      chk("c3_u1_cmd", u1_cmd, 16'h0001);
      @(negedge clk);
      chk("c4_addr", imem_addr, 16'h0001);
      chk("c4_cnt", instr_count, 1);
      chk("c4_u1_wrap", u1_addr, 16'h0000);
      chk("c4_u1_req", u1_req, 1);
      chk("c4_u1_cnt", u1_cnt, 1);
      chk("c4_u1_halted", u1_halted, 0);
      // memory waits 3 cycles, then execute stalls 4 cycles with a PC_load pulse
      @(posedge clk); #1 imem_ack = 0;
      @(negedge clk);
      n = 0;
      repeat (3) begin @(negedge clk); n += int'(imem_req); end
      @(posedge clk); #1 imem_ack = 1; cmd_ready = 0; PC_load = 1; branch_target = 16'h0040;
      @(negedge clk);
      n += int'(imem_req);
      chk("wait_req_cycles", n, 4);
      n = 0;
      repeat (4) begin @(negedge clk); n += int'(cmd_valid); end
      chk("stall_valid_cycles", n, 4);
      @(posedge clk); #1 cmd_ready = 1; PC_load = 0;
      @(negedge clk);
      @(negedge clk);
      chk("count_once", instr_count, 3);
      chk("no_branch_addr", imem_addr, 16'h0003);
      // taken branch to 0x0040, then to 5 where HLT sits
      @(posedge clk); #1 cmd_ready = 0;
      wait_valid("br0_valid");
      accept_with(1, 16'h0040);
      @(negedge clk);
      chk("br_addr", imem_addr, 16'h0040);
      chk("br_req", imem_req, 1);
      wait_valid("br1_valid");
      chk("br_pc", pc_out, 16'h0040);
      accept_with(1, 16'h0005);
      wait_valid("hlt_valid");
      chk("hlt_cmd", COMMAND, 16'hC0F0);
      accept_with(1, 16'h0077);
      cmd_ready = 1;
      n = 0;
      a0 = 0;
      repeat (20) begin
         @(negedge clk);
         n += int'(imem_req);
         a0 += int'(halted);
      end
      chk("halt_req_cycles", n, 0);
      chk("halt_cycles", a0, 20);
      chk("halt_pc_out", pc_out, 16'h0005);
      chk("halt_count", instr_count, 6);
      rst_pulse();
      wait_valid("restart_valid");
      chk("restart_pc", pc_out, 16'h0000);
      // reset during FETCH with ack in the reset cycle
      imem_ack = 0;
      n = 0;
      @(negedge clk);
      while (!imem_req && n < 50) begin @(negedge clk); n++; end
      chk("fetch_seen", imem_req, 1);
      @(posedge clk); #1 reset = 1; imem_ack = 1;
      @(posedge clk); #1 reset = 0;
      @(negedge clk);
      chk("rf_cmd", COMMAND, 16'h0000);
      wait_valid("rf_restart");
      chk("rf_restart_pc", pc_out, 16'h0000);
      // reset during ISSUE
      rst_pulse();
      wait_valid("ri_valid");
      rst_pulse();
      @(negedge clk);
      chk("ri_valid_low", cmd_valid, 0);
      wait_valid("ri_restart");
      chk("ri_restart_pc", pc_out, 16'h0000);
      // random segments
      for (int s = 0; s < 8; s++) begin
         @(posedge clk); #1 reset = 1;
         @(posedge clk); #1 reset = 0;
         a0 = accepts;
         repeat (300) begin
            @(posedge clk); #1
            imem_ack = $urandom_range(0, 2) != 0;
            cmd_ready = $urandom_range(0, 2) != 0;
            PC_load = $urandom_range(0, 3) == 0;
            case ($urandom_range(0, 3))
               0: branch_target = 16'h0040;
               1: branch_target = 16'hFFFF;
               2: branch_target = 16'h0005;
               default: branch_target = 16'($urandom);
            endcase
         end
         chk("progress", accepts > a0, 1);
      end
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
